// File: rtl/lfsr_checker.sv
// Serial PRBS checker for the 5-bit XNOR LFSR (taps s[2],s[3],s[4]): seeds, verifies, then counts errors.
// Optional auto-resync after 4 consecutive locked mismatches: define LFSR_CHECKER_RESYNC_EN.
module lfsr_checker #(
  parameter int LOCK_LEN = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_LEN - 1);

  state_t           state_q, state_d;
  logic [4:0]       s_q, s_d;
  logic [2:0]       seed_cnt_q, seed_cnt_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
`ifdef LFSR_CHECKER_RESYNC_EN
  logic [1:0]       miss_cnt_q, miss_cnt_d;
`endif

  logic exp_bit;
  logic mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign exp_bit  = ~(s_q[2] ^ s_q[3] ^ s_q[4]);
  assign mismatch = in_bit ^ exp_bit;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    bit_cnt_d   = bit_cnt_q;
`ifdef LFSR_CHECKER_RESYNC_EN
    miss_cnt_d  = miss_cnt_q;
`endif
    if (clr) begin
      state_d     = SEED;
      s_d         = '0;
      seed_cnt_d  = '0;
      match_cnt_d = '0;
      err_cnt_d   = '0;
      bit_cnt_d   = '0;
`ifdef LFSR_CHECKER_RESYNC_EN
      miss_cnt_d  = '0;
`endif
    end else if (in_valid) begin
      case (state_q)
        SEED: begin
          s_d = {s_q[3:0], in_bit};
          if (seed_cnt_q == 3'd4) begin
            state_d     = VERIFY;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
          end else begin
            seed_cnt_d = seed_cnt_q + 3'd1;
          end
        end
        VERIFY: begin
          // Model bit is fed back so a corrupted received bit never enters s.
          s_d = {s_q[3:0], exp_bit};
          if (mismatch) begin
            state_d     = SEED;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
          end else if (match_cnt_q == LOCK_LAST) begin
            state_d     = LOCKED;
            match_cnt_d = '0;
`ifdef LFSR_CHECKER_RESYNC_EN
            miss_cnt_d  = '0;
`endif
          end else begin
            match_cnt_d = match_cnt_q + 4'd1;
          end
        end
        LOCKED: begin
          s_d       = {s_q[3:0], exp_bit};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (mismatch) begin
            err_d     = 1'b1;
            err_cnt_d = sat_inc(err_cnt_q);
          end
`ifdef LFSR_CHECKER_RESYNC_EN
          if (!mismatch) begin
            miss_cnt_d = '0;
          end else if (miss_cnt_q == 2'd3) begin
            state_d    = SEED;
            seed_cnt_d = '0;
            miss_cnt_d = '0;
          end else begin
            miss_cnt_d = miss_cnt_q + 2'd1;
          end
`endif
        end
        default: begin
          state_d    = SEED;
          seed_cnt_d = '0;
        end
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SEED;
      s_q         <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
`ifdef LFSR_CHECKER_RESYNC_EN
      miss_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      err_q       <= err_d;
      locked_q    <= locked_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
`ifdef LFSR_CHECKER_RESYNC_EN
      miss_cnt_q  <= miss_cnt_d;
`endif
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign bit_cnt = bit_cnt_q;
  assign state   = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised self-checking bench for lfsr_checker against a queue-based behavioural model.
module tb_lfsr_checker;
  localparam int LOCK_LEN = 8;
  localparam int CNT_W    = 8;
  localparam int CNT_MOD  = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             locked, err;
  logic [CNT_W-1:0] err_cnt, bit_cnt;
  logic [1:0]       state;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  lfsr_checker #(.LOCK_LEN(LOCK_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_bit(in_bit),
    .locked(locked), .err(err), .err_cnt(err_cnt), .bit_cnt(bit_cnt), .state(state)
  );

  always #5 clk = ~clk;

  // Transmitter: history of generated bits, newest at the back.
  bit gq[$];
  // Checker model: mode 0/1/2 = seeding/verifying/locked, history of model bits.
  bit mq[$];
  int m_mode, m_cnt, m_err_cnt, m_bit_cnt, m_miss;
  bit m_err;

  function automatic bit next_of(input bit q[$]);
    int n = q.size();
    return ~(q[n-3] ^ q[n-4] ^ q[n-5]);
  endfunction

  function automatic bit gen_next();
    bit b = next_of(gq);
    gq.push_back(b);
    void'(gq.pop_front());
    return b;
  endfunction

  function automatic void model_reset();
    mq = '{0, 0, 0, 0, 0};
    m_mode = 0; m_cnt = 0; m_err_cnt = 0; m_bit_cnt = 0; m_miss = 0; m_err = 0;
  endfunction

  function automatic void model_step(input bit v, input bit b, input bit c);
    bit e;
    m_err = 0;
    if (c) begin
      model_reset();
    end else if (v) begin
      e = next_of(mq);
      mq.push_back(m_mode == 0 ? b : e);
      void'(mq.pop_front());
      if (m_mode == 0) begin
        m_cnt++;
        if (m_cnt == 5) begin m_mode = 1; m_cnt = 0; end
      end else if (m_mode == 1) begin
        if (b != e) begin m_mode = 0; m_cnt = 0; end
        else begin
          m_cnt++;
          if (m_cnt == LOCK_LEN) begin m_mode = 2; m_cnt = 0; end
        end
      end else begin
        m_bit_cnt = (m_bit_cnt + 1) % CNT_MOD;
        if (b != e) begin
          m_err = 1;
          if (m_err_cnt < CNT_MOD - 1) m_err_cnt++;
        end
`ifdef LFSR_CHECKER_RESYNC_EN
        if (b != e) begin
          m_miss++;
          if (m_miss == 4) begin m_mode = 0; m_cnt = 0; m_miss = 0; end
        end else m_miss = 0;
`endif
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_state", state, m_mode);
      chk("cyc_locked", locked, (m_mode == 2) ? 1 : 0);
      chk("cyc_err", err, m_err);
      chk("cyc_err_cnt", err_cnt, m_err_cnt);
      chk("cyc_bit_cnt", bit_cnt, m_bit_cnt);
    end
  end

  task automatic step(input bit v, input bit b, input bit c);
    in_valid = v; in_bit = b; clr = c;
    @(posedge clk);
    #1;
    model_step(v, b, c);
  endtask

  task automatic feed_good(input int n);
    for (int i = 0; i < n; i++) step(1'b1, gen_next(), 1'b0);
  endtask

  task automatic pulse_rst();
    rst = 1'b0;
    model_reset();
    #2;
    chk("rst_async_state", state, 0);
    chk("rst_async_locked", locked, 0);
    chk("rst_async_err_cnt", err_cnt, 0);
    chk("rst_async_bit_cnt", bit_cnt, 0);
    rst = 1'b1;
  endtask

  initial begin
    int pat[5] = '{1, 1, 1, 0, 1};
    bit b;
    gq = '{0, 0, 0, 0, 0};
    model_reset();
    #12;
    rst = 1'b1;
    chk_en = 1;
    chk("reset_state", state, 0);
    chk("reset_err", err, 0);
    chk("reset_err_cnt", err_cnt, 0);

    // Lock on the clean stream from an all-zero generator.
    for (int i = 0; i < 13; i++) begin
      b = gen_next();
      if (i < 5) chk("gen_seq", b, pat[i]);
      if (i == 12) chk("not_locked_before_13", locked, 0);
      step(1'b1, b, 1'b0);
    end
    chk("lock_after_13", locked, 1);
    chk("lock_state", state, 2);

    // Idle cycles hold everything.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);

    // Single flipped bit while locked.
    step(1'b1, ~gen_next(), 1'b0);
    chk("flip_err_pulse", err, 1);
    chk("flip_err_cnt", err_cnt, 1);
    step(1'b1, gen_next(), 1'b0);
    chk("flip_err_drop", err, 0);
    feed_good(10);
    chk("flip_err_cnt_hold", err_cnt, 1);
    chk("flip_bit_cnt", bit_cnt, 12);

    // Mismatch on the 3rd verify bit.
    pulse_rst();
    feed_good(7);
    step(1'b1, ~gen_next(), 1'b0);
    chk("verify_miss_state", state, 0);
    chk("verify_miss_locked", locked, 0);
    chk("verify_miss_err_cnt", err_cnt, 0);

    // 300 errors interleaved with good bits: saturation and wrap.
    pulse_rst();
    feed_good(13);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, ~gen_next(), 1'b0);
      step(1'b1, gen_next(), 1'b0);
    end
    chk("sat_err_cnt", err_cnt, 255);
    chk("wrap_bit_cnt", bit_cnt, 600 % 256);

    // Four consecutive errors while locked.
    pulse_rst();
    feed_good(13);
    for (int i = 0; i < 4; i++) step(1'b1, ~gen_next(), 1'b0);
    chk("burst_err_cnt", err_cnt, 4);
`ifdef LFSR_CHECKER_RESYNC_EN
    chk("burst_resync_state", state, 0);
    chk("burst_resync_locked", locked, 0);
    feed_good(13);
    chk("burst_relock", locked, 1);
    chk("burst_retained_err_cnt", err_cnt, 4);
`else
    chk("burst_stay_locked", locked, 1);
    chk("burst_stay_state", state, 2);
`endif

    // clr together with in_valid while locked.
    feed_good(5);
    step(1'b1, ~gen_next(), 1'b1);
    chk("clr_state", state, 0);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_bit_cnt", bit_cnt, 0);
    chk("clr_locked", locked, 0);
    feed_good(12);
    chk("clr_not_yet", locked, 0);
    feed_good(1);
    chk("clr_relock", locked, 1);

    // Reset mid-stream.
    feed_good(20);
    pulse_rst();
    feed_good(13);
    chk("rst_relock", locked, 1);
    chk("rst_relock_err_cnt", err_cnt, 0);

    // Randomised traffic with gaps, flips and occasional clr.
    pulse_rst();
    for (int i = 0; i < 3000; i++) begin
      bit v, f, c;
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 39) == 0);
      c = ($urandom_range(0, 499) == 0);
      if (v) step(1'b1, gen_next() ^ f, c);
      else   step(1'b0, 1'($urandom_range(0, 1)), c);
    end

    step(1'b0, 1'b0, 1'b0);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
